// File: rtl/stmt_lowerer_rr_arbiter.sv
// N-channel round-robin arbiter with a one-beat registered output stage.
// The current owner may keep the grant for up to MAX_HOLD consecutive beats.
module stmt_lowerer_rr_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int LOCK_EN  = 1,
    parameter int MAX_HOLD = 4,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // With unlimited hold the counter just pins at its maximum.
    localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    logic              slot_open;
    logic              lock_hit;
    logic              win_found;
    logic [CH_W-1:0]   win_ch;
    logic [CH_W-1:0]   cand;

    assign slot_open = (state_q == IDLE) || out_ready;

    always_comb begin
        win_found = 1'b0;
        win_ch    = last_q;
        cand      = last_q;
        lock_hit  = (LOCK_EN != 0) && (state_q == BUSY) && req[last_q] &&
                    ((MAX_HOLD == 0) || (burst_cnt_q < CNT_SAT));
        if (lock_hit) begin
            win_found = 1'b1;
        end else begin
            // Scan starts just past the last owner and ends on the last owner itself.
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                cand = CH_W'((32'(last_q) + k) % NUM_CH);
                if (req[cand]) begin
                    win_found = 1'b1;
                    win_ch    = cand;
                    break;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        ch_d        = ch_q;
        if (slot_open) begin
            if (win_found) begin
                data_d  = data_in[win_ch*DATA_W +: DATA_W];
                ch_d    = win_ch;
                state_d = BUSY;
                if ((win_ch == last_q) && (state_q == BUSY)) begin
                    if (burst_cnt_q != CNT_SAT) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    burst_cnt_d = CNT_W'(1);
                    last_d      = win_ch;
                end
            end else if (state_q == BUSY) begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (rst_n && slot_open && win_found) begin
            gnt[win_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= CH_W'(NUM_CH - 1);
            burst_cnt_q <= '0;
            data_q      <= '0;
            ch_q        <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
        end
    end

    assign out_valid = (state_q == BUSY);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_stmt_lowerer_rr_arbiter.sv
// Directed bench for stmt_lowerer_rr_arbiter: a locking instance (MAX_HOLD=2)
// and a non-locking instance, with expected beats checked through queues.
module tb_stmt_lowerer_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        out_ready;
    logic [3:0]  gnt, gnt2;
    logic        ov, ov2;
    logic [7:0]  od, od2;
    logic [1:0]  oc, oc2;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    stmt_lowerer_rr_arbiter #(.NUM_CH(4), .DATA_W(8), .LOCK_EN(1), .MAX_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .gnt(gnt),
        .out_valid(ov), .out_ready(out_ready), .out_data(od), .out_ch(oc)
    );

    stmt_lowerer_rr_arbiter #(.NUM_CH(4), .DATA_W(8), .LOCK_EN(0), .MAX_HOLD(2)) dut_nl (
        .clk(clk), .rst_n(rst2_n), .req(req), .data_in(data_in), .gnt(gnt2),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ch(oc2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [3:0] g, input logic [31:0] d);
        beat_t b;
        b.ch = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) b.ch = 2'(i);
        b.data = d[b.ch*8 +: 8];
        return b;
    endfunction

    // Drive one cycle; eg/eg2 are the hand-computed grants of each instance.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic rdy,
                        input logic [3:0] eg, input logic [3:0] eg2);
        req       = r;
        data_in   = d;
        out_ready = rdy;
        if (eg != 4'd0)  q1.push_back(mk(eg, d));
        if (eg2 != 4'd0) q2.push_back(mk(eg2, d));
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_nolock", 32'(gnt2), 32'(eg2));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ov && out_ready) begin
            chk("beat_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                beat_t b;
                b = q1.pop_front();
                chk("out_ch", 32'(oc), 32'(b.ch));
                chk("out_data", 32'(od), 32'(b.data));
            end
        end
    end

    always @(negedge clk) begin
        if (ov2 && out_ready) begin
            chk("beat_expected_nolock", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                beat_t b;
                b = q2.pop_front();
                chk("out_ch_nolock", 32'(oc2), 32'(b.ch));
                chk("out_data_nolock", 32'(od2), 32'(b.data));
            end
        end
    end

    initial begin
        logic [3:0] seq1 [9];
        logic [3:0] seq2 [6];
        seq1 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        seq2 = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};

        rst_n = 1'b0; rst2_n = 1'b0;
        req = 4'hF; data_in = 32'hA3A2A1A0; out_ready = 1'b1;
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", 32'(od), 32'd0);
        chk("rst_ch", 32'(oc), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Four requesters, two-beat lock each
        for (int i = 0; i < 9; i++) step(4'hF, 32'hA3A2A1A0, 1'b1, seq1[i], 4'd0);

        // Drain to IDLE, payload holds
        step(4'h0, 32'hA3A2A1A0, 1'b1, 4'd0, 4'd0);
        chk("drain_valid", 32'(ov), 32'd0);
        chk("drain_data", 32'(od), 32'hA0);
        chk("drain_ch", 32'(oc), 32'd0);

        // Stall with ch2 requesting
        step(4'b0100, 32'h00770000, 1'b1, 4'b0100, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 32'h00770000, 1'b0, 4'd0, 4'd0);
            chk("stall_valid", 32'(ov), 32'd1);
            chk("stall_data", 32'(od), 32'h77);
            chk("stall_ch", 32'(oc), 32'd2);
        end
        step(4'b0100, 32'h00780000, 1'b1, 4'b0100, 4'd0);
        chk("post_stall_data", 32'(od), 32'h78);
        step(4'h0, 32'h0, 1'b1, 4'd0, 4'd0);

        // Lone ch3: granted every cycle through lock expiry
        for (int i = 0; i < 5; i++) begin
            step(4'b1000, 32'h5C000000, 1'b1, 4'b1000, 4'd0);
            chk("solo_valid", 32'(ov), 32'd1);
        end
        chk("burst_sat", 32'(dut.burst_cnt_q), 32'd2);

        // Asynchronous reset mid-stream discards the held beat
        rst_n = 1'b0;
        q1.delete();
        #1;
        chk("async_valid", 32'(ov), 32'd0);
        chk("async_data", 32'(od), 32'd0);
        chk("async_ch", 32'(oc), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);

        // Non-locking instance alternates between ch1 and ch3
        rst2_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(4'b1010, 32'h0D0C0B0A, 1'b1, 4'd0, seq2[i]);
            chk("nolock_valid", 32'(ov2), 32'd1);
        end
        for (int i = 0; i < 3; i++) step(4'b0100, 32'h00660000, 1'b1, 4'd0, 4'b0100);
        step(4'h0, 32'h0, 1'b1, 4'd0, 4'd0);
        chk("nolock_drain", 32'(ov2), 32'd0);
        rst2_n = 1'b0;

        // After reset release, channel 0 wins first
        rst_n = 1'b1;
        step(4'b1001, 32'h31000030, 1'b1, 4'b0001, 4'd0);
        step(4'b1001, 32'h31000030, 1'b1, 4'b0001, 4'd0);
        step(4'b1000, 32'h31000030, 1'b1, 4'b1000, 4'd0);
        step(4'h0, 32'h0, 1'b1, 4'd0, 4'd0);
        step(4'h0, 32'h0, 1'b1, 4'd0, 4'd0);

        chk("q_empty", 32'(q1.size()), 32'd0);
        chk("q_empty_nolock", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
